// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C bus arbiter.
//   arb_state_e : bus ownership states (idle, external host, local master, forced release)
//   I2C_REL     : released (high-Z) level of an open-drain enable
package i2c_arb_pkg;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_LOC, S_REL} arb_state_e;

  localparam logic I2C_REL = 1'b1;

endpackage

// File: rtl/i2c_cond_detect.sv
// Bus condition detector: synchronises SCL/SDA and flags START, STOP and SCL edges.
// Conditions compare the previous tick's sample against the current one, so every
// output pulse is qualified by clk_en and lasts one clk.
//   clk, rst, clk_en       : clock, synchronous active-high reset, sample tick
//   scl_i, sda_i           : raw pad levels
//   scl_o, sda_o           : synchronised levels
//   start_o, stop_o        : START / STOP seen on this tick
//   scl_edge_o             : SCL changed level since the previous tick
module i2c_cond_detect
  import i2c_arb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_o,
  output logic sda_o,
  output logic start_o,
  output logic stop_o,
  output logic scl_edge_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q;
  logic [SYNC_STAGES-1:0] sda_sync_q;
  logic                   scl_prev_q;
  logic                   sda_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= {SYNC_STAGES{I2C_REL}};
      sda_sync_q <= {SYNC_STAGES{I2C_REL}};
      scl_prev_q <= I2C_REL;
      sda_prev_q <= I2C_REL;
    end else begin
      scl_sync_q[0] <= scl_i;
      sda_sync_q[0] <= sda_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync_q[i] <= scl_sync_q[i-1];
        sda_sync_q[i] <= sda_sync_q[i-1];
      end
      if (clk_en) begin
        scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
        sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
      end
    end
  end

  assign scl_o = scl_sync_q[SYNC_STAGES-1];
  assign sda_o = sda_sync_q[SYNC_STAGES-1];

  // SCL must be high on both samples for SDA movement to count as a condition.
  assign start_o    = clk_en & scl_prev_q & scl_o & sda_prev_q & ~sda_o;
  assign stop_o     = clk_en & scl_prev_q & scl_o & ~sda_prev_q & sda_o;
  assign scl_edge_o = clk_en & (scl_prev_q ^ scl_o);

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one open-drain I2C bus between the external-host bridge and a local master.
// The local master is granted the bus only after IDLE_TICKS quiet ticks; after it lets
// go the bus is forced released for IDLE_TICKS ticks before returning to the bridge.
//   clk, rst, clk_en             : clock, synchronous active-high reset, sample tick
//   scl_i, sda_i                 : sensed bus levels
//   bridge_scl_t, bridge_sda_t   : bridge enables (1 = release)
//   loc_req, loc_scl_t, loc_sda_t: local master request and enables
//   loc_gnt                      : local master owns the bus
//   scl_t, sda_t                 : registered pad enables (1 = high-Z)
//   bus_busy                     : bus owned by anyone or in forced release
//   timeout                      : one-clk pulse when an external transaction stalls
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned IDLE_TICKS    = 8,
  parameter int unsigned TIMEOUT_TICKS = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic scl_i,
  input  logic sda_i,
  input  logic bridge_scl_t,
  input  logic bridge_sda_t,
  input  logic loc_req,
  input  logic loc_scl_t,
  input  logic loc_sda_t,
  output logic loc_gnt,
  output logic scl_t,
  output logic sda_t,
  output logic bus_busy,
  output logic timeout
);

  localparam int unsigned IdleW = $clog2(IDLE_TICKS + 1);
  localparam int unsigned WdW   = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(IDLE_TICKS);
  localparam logic [WdW-1:0]   WdMax   = WdW'(TIMEOUT_TICKS);

  logic scl_s, sda_s, start, stop, scl_edge;

  arb_state_e       state_q, state_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d, idle_cnt_inc;
  logic [IdleW-1:0] rel_cnt_q, rel_cnt_d;
  logic [WdW-1:0]   wd_cnt_q, wd_cnt_d;
  logic             scl_t_q, scl_t_d;
  logic             sda_t_q, sda_t_d;
  logic             timeout_q, timeout_d;

  i2c_cond_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_cond_detect (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_o     (scl_s),
    .sda_o     (sda_s),
    .start_o   (start),
    .stop_o    (stop),
    .scl_edge_o(scl_edge)
  );

  // Quiet-bus counter, saturating at IDLE_TICKS.
  always_comb begin
    idle_cnt_inc = idle_cnt_q;
    if (clk_en) begin
      if (!scl_s || !sda_s) begin
        idle_cnt_inc = '0;
      end else if (!start && idle_cnt_q != IdleMax) begin
        idle_cnt_inc = idle_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_inc;
    rel_cnt_d  = '0;
    wd_cnt_d   = '0;
    timeout_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // START wins over a grant that would mature on the same tick.
        if (start) begin
          state_d = S_EXT;
        end else if (clk_en && loc_req && idle_cnt_inc == IdleMax) begin
          state_d = S_LOC;
        end
      end
      S_EXT: begin
        wd_cnt_d = wd_cnt_q;
        if (clk_en) begin
          if (scl_edge) begin
            wd_cnt_d = '0;
          end else if (wd_cnt_q != WdMax) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
          if (stop) begin
            state_d  = S_IDLE;
            wd_cnt_d = '0;
          end else if (wd_cnt_d == WdMax) begin
            state_d   = S_IDLE;
            wd_cnt_d  = '0;
            timeout_d = 1'b1;
          end
        end
      end
      S_LOC: begin
        if (clk_en && !loc_req) begin
          state_d = S_REL;
        end
      end
      S_REL: begin
        rel_cnt_d = rel_cnt_q;
        if (clk_en) begin
          rel_cnt_d = rel_cnt_q + 1'b1;
          if (rel_cnt_d == IdleMax) begin
            state_d    = S_IDLE;
            rel_cnt_d  = '0;
            idle_cnt_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pad mux follows the current owner; registering it adds one clk of latency.
  always_comb begin
    scl_t_d = bridge_scl_t;
    sda_t_d = bridge_sda_t;
    unique case (state_q)
      S_LOC: begin
        scl_t_d = loc_scl_t;
        sda_t_d = loc_sda_t;
      end
      S_REL: begin
        scl_t_d = I2C_REL;
        sda_t_d = I2C_REL;
      end
      default: begin
        scl_t_d = bridge_scl_t;
        sda_t_d = bridge_sda_t;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idle_cnt_q <= '0;
      rel_cnt_q  <= '0;
      wd_cnt_q   <= '0;
      scl_t_q    <= I2C_REL;
      sda_t_q    <= I2C_REL;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      rel_cnt_q  <= rel_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      scl_t_q    <= scl_t_d;
      sda_t_q    <= sda_t_d;
      timeout_q  <= timeout_d;
    end
  end

  assign loc_gnt  = (state_q == S_LOC);
  assign bus_busy = (state_q != S_IDLE);
  assign scl_t    = scl_t_q;
  assign sda_t    = sda_t_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter. The bus is modelled as a wired-AND of the DUT pad
// enables and an external driver; clk_en pulses one clk in every four.
module tb_i2c_bus_arbiter;

  logic clk, rst, clk_en;
  logic bridge_scl_t, bridge_sda_t;
  logic loc_req, loc_scl_t, loc_sda_t;
  logic loc_gnt, scl_t, sda_t, bus_busy, timeout;
  logic ext_scl, ext_sda;
  logic scl_bus, sda_bus;

  int vectors     = 0;
  int miscompares = 0;
  int n;
  int bad;

  assign scl_bus = scl_t & ext_scl;
  assign sda_bus = sda_t & ext_sda;

  i2c_bus_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .scl_i       (scl_bus),
    .sda_i       (sda_bus),
    .bridge_scl_t(bridge_scl_t),
    .bridge_sda_t(bridge_sda_t),
    .loc_req     (loc_req),
    .loc_scl_t   (loc_scl_t),
    .loc_sda_t   (loc_sda_t),
    .loc_gnt     (loc_gnt),
    .scl_t       (scl_t),
    .sda_t       (sda_t),
    .bus_busy    (bus_busy),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // clk_en changes on the falling edge so it is stable at every rising edge.
  initial begin
    clk_en = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      clk_en = 1'b1;
      @(negedge clk);
      clk_en = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: observed still running, expected finished");
    $fatal(1, "time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge on which clk_en is high.
  task automatic tick();
    do @(posedge clk); while (clk_en !== 1'b1);
    #1;
  endtask

  task automatic bus(input logic s, input logic d);
    ext_scl = s;
    ext_sda = d;
    tick();
  endtask

  task automatic xfer(input logic s, input logic d);
    bus(s, d);
    if (bus_busy !== 1'b1 || loc_gnt !== 1'b0) bad++;
  endtask

  initial begin
    logic [8:0] data;
    rst          = 1'b1;
    loc_req      = 1'b1;
    loc_scl_t    = 1'b1;
    loc_sda_t    = 1'b1;
    bridge_scl_t = 1'b1;
    bridge_sda_t = 1'b1;
    ext_scl      = 1'b1;
    ext_sda      = 1'b1;
    data         = 9'b1_0110_0101;

    repeat (3) @(posedge clk);
    #1;
    check("rst_scl_t", scl_t, 1);
    check("rst_sda_t", sda_t, 1);
    check("rst_loc_gnt", loc_gnt, 0);
    check("rst_bus_busy", bus_busy, 0);
    check("rst_timeout", timeout, 0);

    // Grant after exactly 8 idle ticks following reset.
    @(negedge clk);
    rst = 1'b0;
    n   = 0;
    bad = 0;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      tick();
      if (loc_gnt === 1'b1) n = i;
      else if (scl_t !== 1'b1 || sda_t !== 1'b1) bad++;
    end
    check("grant_ticks_after_reset", n, 8);
    check("released_before_grant", bad, 0);

    // Local drive passes through; bridge ignored while local owns the bus.
    loc_scl_t    = 1'b0;
    bridge_sda_t = 1'b0;
    @(posedge clk);
    #1;
    check("loc_scl_drive", scl_t, 0);
    check("bridge_sda_ignored_loc", sda_t, 1);

    loc_req = 1'b0;
    tick();
    check("rel_entry_gnt", loc_gnt, 0);
    check("rel_entry_busy", bus_busy, 1);
    check("rel_entry_scl_lag", scl_t, 0);
    @(posedge clk);
    #1;
    check("rel_scl_released", scl_t, 1);

    n   = 0;
    bad = 0;
    for (int i = 1; i <= 12 && n == 0; i++) begin
      tick();
      if (bus_busy === 1'b0) n = i;
      else if (sda_t !== 1'b1) bad++;
      if (i == 7) bridge_sda_t = 1'b1;
    end
    check("rel_length_ticks", n, 8);
    check("bridge_sda_ignored_rel", bad, 0);
    loc_scl_t = 1'b1;

    // START on the tick loc_req rises with a saturated idle counter.
    repeat (10) tick();
    loc_req = 1'b1;
    bus(1'b1, 1'b0);
    check("start_vs_grant_busy", bus_busy, 1);
    check("start_vs_grant_gnt", loc_gnt, 0);

    // 9-bit external transfer then STOP with loc_req held.
    bad = 0;
    xfer(1'b0, 1'b0);
    for (int b = 8; b >= 0; b--) begin
      xfer(1'b0, data[b]);
      xfer(1'b1, data[b]);
    end
    xfer(1'b0, 1'b0);
    xfer(1'b1, 1'b0);
    check("ext_busy_no_gnt", bad, 0);
    bus(1'b1, 1'b1);
    check("stop_to_idle", bus_busy, 0);
    // The STOP tick itself is the first idle tick.
    n = 0;
    for (int i = 2; i <= 20 && n == 0; i++) begin
      tick();
      if (loc_gnt === 1'b1) n = i;
    end
    check("grant_ticks_after_stop", n, 8);

    // Reset while the local master holds both lines low.
    loc_scl_t = 1'b0;
    loc_sda_t = 1'b0;
    @(posedge clk);
    #1;
    check("loc_both_low_scl", scl_t, 0);
    check("loc_both_low_sda", sda_t, 0);
    @(negedge clk);
    rst     = 1'b1;
    loc_req = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_loc_scl_t", scl_t, 1);
    check("rst_in_loc_sda_t", sda_t, 1);
    check("rst_in_loc_gnt", loc_gnt, 0);
    check("rst_in_loc_busy", bus_busy, 0);
    loc_scl_t = 1'b1;
    loc_sda_t = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // START then SCL stuck high: watchdog fires after 4096 ticks in EXT.
    tick();
    tick();
    bus(1'b1, 1'b0);
    check("wd_start_busy", bus_busy, 1);
    n = 0;
    for (int i = 1; i <= 5000 && n == 0; i++) begin
      tick();
      if (timeout === 1'b1) n = i;
    end
    check("timeout_ticks", n, 4096);
    check("timeout_idle_busy", bus_busy, 0);
    @(posedge clk);
    #1;
    check("timeout_one_clk", timeout, 0);
    bus(1'b1, 1'b1);

    // Bridge pass-through in IDLE with one clk latency.
    bridge_scl_t = 1'b0;
    @(posedge clk);
    #1;
    check("bridge_scl_passthrough", scl_t, 0);
    bridge_scl_t = 1'b1;
    @(posedge clk);
    #1;
    check("bridge_scl_release", scl_t, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
